// File: rtl/elevator_pkg.sv
// Shared constants for the elevator datapath slice.
// - ELEV_FLOORS   : default number of floors.
// - FLOOR0_ONEHOT : one-hot encoding of floor 0, used as the reset value of
//                   the floor register. It is 32 bits wide so it covers the
//                   largest legal floor count; users take the low N bits.
package elevator_pkg;

  localparam int ELEV_FLOORS = 5;

  localparam logic [31:0] FLOOR0_ONEHOT = 32'd1;

endpackage

// File: rtl/elevator_datapath_if.sv
// Controller <-> datapath bundle for the elevator datapath.
// Signals:
//   open, up, down     : controller commands (door open, move up, move down)
//   button_out         : hall call buttons, one bit per floor, active-low
//   button_in          : car floor-select buttons, one bit per floor, active-low
//   request_i          : a request is pending at the current floor
//   request_j_gt_i     : a request is pending above the current floor
//   request_j_lt_i     : a request is pending below the current floor
//   i                  : current floor, one-hot
// Modports:
//   master : the controller / stimulus side
//   slave  : the datapath side
interface elevator_datapath_if
  import elevator_pkg::*;
#(
  parameter int N = ELEV_FLOORS
);

  logic         open;
  logic         up;
  logic         down;
  logic [N-1:0] button_out;
  logic [N-1:0] button_in;
  logic         request_i;
  logic         request_j_gt_i;
  logic         request_j_lt_i;
  logic [N-1:0] i;

  modport master (
    output open, up, down, button_out, button_in,
    input  request_i, request_j_gt_i, request_j_lt_i, i
  );

  modport slave (
    input  open, up, down, button_out, button_in,
    output request_i, request_j_gt_i, request_j_lt_i, i
  );

endinterface

// File: rtl/elevator_datapath_floor_cmp.sv
// floor_cmp: compares the pending-request vector against the one-hot current
// floor and reports whether a request is pending at, above, or below it.
// Ports:
//   req            : pending requests, one bit per floor
//   i              : current floor, one-hot
//   request_i      : request pending at the current floor
//   request_j_gt_i : request pending at any floor above the current floor
//   request_j_lt_i : request pending at any floor below the current floor
module floor_cmp
  import elevator_pkg::*;
#(
  parameter int N = ELEV_FLOORS
) (
  input  logic [N-1:0] req,
  input  logic [N-1:0] i,
  output logic         request_i,
  output logic         request_j_gt_i,
  output logic         request_j_lt_i
);

  logic [N-1:0] below_mask;
  logic [N-1:0] above_mask;

  // For a one-hot i, i-1 sets exactly the bits below the current floor;
  // everything that is neither the floor nor below it is above it.
  assign below_mask = i - N'(1);
  assign above_mask = ~(i | below_mask);

  assign request_i      = |(req & i);
  assign request_j_gt_i = |(req & above_mask);
  assign request_j_lt_i = |(req & below_mask);

endmodule

// File: rtl/elevator_datapath.sv
// elevator_datapath: pending-request register and one-hot floor register for
// a simple elevator, plus the at/above/below request flags the controller
// uses to decide where to go next.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset (req cleared, car at floor 0)
//   bus : elevator_datapath_if.slave (commands, buttons, request flags, floor)
// Optional build macro:
//   ELEVATOR_DATAPATH_ASSERT_EN : compiles in simulation assertions checking
//   that the floor stays one-hot and that conflicting up/down commands are
//   never issued at an end floor.
module elevator_datapath
  import elevator_pkg::*;
#(
  parameter int N = ELEV_FLOORS
) (
  input  logic                clk,
  input  logic                rst,
  elevator_datapath_if.slave  bus
);

  logic [N-1:0] req;
  logic [N-1:0] floor_q;
  logic [N-1:0] press;
  logic [N-1:0] clear;

  assign press = ~bus.button_out | ~bus.button_in;
  // The clear uses the floor held before the edge, so a simultaneous move
  // does not redirect it, and it wins over a press at that same floor.
  assign clear = bus.open ? floor_q : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      req     <= '0;
      floor_q <= FLOOR0_ONEHOT[N-1:0];
    end else begin
      req <= (req | press) & ~clear;
      // Moves saturate at the end floors; up==down holds.
      if (bus.up && !bus.down && !floor_q[N-1]) begin
        floor_q <= floor_q << 1;
      end else if (bus.down && !bus.up && !floor_q[0]) begin
        floor_q <= floor_q >> 1;
      end
    end
  end

  assign bus.i = floor_q;

  floor_cmp #(.N(N)) u_floor_cmp (
    .req            (req),
    .i              (floor_q),
    .request_i      (bus.request_i),
    .request_j_gt_i (bus.request_j_gt_i),
    .request_j_lt_i (bus.request_j_lt_i)
  );

`ifdef ELEVATOR_DATAPATH_ASSERT_EN
  logic seen_rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      seen_rst <= 1'b1;
    end
  end

  a_onehot: assert property (@(posedge clk) disable iff (rst || (seen_rst !== 1'b1))
    $onehot(floor_q));

  a_no_conflict_at_end: assert property (@(posedge clk) disable iff (rst || (seen_rst !== 1'b1))
    !(bus.up && bus.down && (floor_q[N-1] || floor_q[0])));
`endif

endmodule

// File: tb/tb_elevator_datapath.sv
// Self-checking bench for elevator_datapath: a floor-number / request-array
// model tracks the expected state every cycle, and directed scenarios add
// hand-computed literal expectations.
module tb_elevator_datapath;

  localparam int N = 5;

  logic clk;
  logic rst;

  elevator_datapath_if #(.N(N)) bus ();

  elevator_datapath #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model: floor as an integer, requests as a bit array.
  int     m_floor = 0;
  bit     m_req [N];
  bit     m_valid = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < N; k++) m_req[k] = 1'b0;
      m_floor = 0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      for (int k = 0; k < N; k++)
        if (bus.button_out[k] == 1'b0 || bus.button_in[k] == 1'b0) m_req[k] = 1'b1;
      if (bus.open) m_req[m_floor] = 1'b0;
      if (bus.up && !bus.down && m_floor < N - 1) m_floor = m_floor + 1;
      else if (bus.down && !bus.up && m_floor > 0) m_floor = m_floor - 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_valid) begin
      bit e_at, e_gt, e_lt;
      logic [31:0] e_i;
      e_at = m_req[m_floor];
      e_gt = 1'b0;
      e_lt = 1'b0;
      for (int k = 0; k < N; k++) begin
        if (k > m_floor && m_req[k]) e_gt = 1'b1;
        if (k < m_floor && m_req[k]) e_lt = 1'b1;
      end
      e_i = 32'd1 << m_floor;
      chk("model_i", 32'(bus.i), e_i);
      chk("model_request_i", 32'(bus.request_i), 32'(e_at));
      chk("model_request_j_gt_i", 32'(bus.request_j_gt_i), 32'(e_gt));
      chk("model_request_j_lt_i", 32'(bus.request_j_lt_i), 32'(e_lt));
    end
  end

  task automatic idle();
    bus.open = 1'b0;
    bus.up = 1'b0;
    bus.down = 1'b0;
    bus.button_out = '1;
    bus.button_in = '1;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic lit(input string name, input logic [N-1:0] ei, input bit ea, input bit eg, input bit el);
    chk({name, "_i"}, 32'(bus.i), 32'(ei));
    chk({name, "_at"}, 32'(bus.request_i), 32'(ea));
    chk({name, "_gt"}, 32'(bus.request_j_gt_i), 32'(eg));
    chk({name, "_lt"}, 32'(bus.request_j_lt_i), 32'(el));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

  initial begin
    idle();
    rst = 1'b1;
    @(negedge clk);
    cyc(2);
    rst = 1'b0;
    lit("reset", 5'b00001, 0, 0, 0);

    // Latch floors 0 and 2 from hall buttons.
    bus.button_out = 5'b11010;
    cyc(1);
    idle();
    lit("latch", 5'b00001, 1, 1, 0);
    cyc(2);
    lit("latch_hold", 5'b00001, 1, 1, 0);

    // Service floor 0, then travel to floor 2.
    bus.open = 1'b1;
    cyc(1);
    idle();
    lit("open0", 5'b00001, 0, 1, 0);
    bus.up = 1'b1;
    cyc(2);
    idle();
    lit("arrive2", 5'b00100, 1, 0, 0);

    // Open at floor 2 while floors 2 and 0 are pressed: clear wins at 2.
    bus.button_in = 5'b11010;
    bus.open = 1'b1;
    cyc(1);
    idle();
    lit("collision", 5'b00100, 0, 0, 1);

    // Press floor 4; up and down together hold the car.
    bus.button_out = 5'b01111;
    bus.up = 1'b1;
    bus.down = 1'b1;
    cyc(1);
    idle();
    lit("updown_hold", 5'b00100, 0, 1, 1);

    // Down to floor 0 and beyond: saturates.
    bus.down = 1'b1;
    cyc(3);
    lit("down_sat", 5'b00001, 1, 1, 0);
    idle();
    bus.up = 1'b1;
    cyc(6);
    idle();
    lit("up_sat", 5'b10000, 1, 0, 1);

    // Build req=10101 at floor 3, then reset mid-move with presses.
    bus.down = 1'b1;
    cyc(1);
    idle();
    bus.button_out = 5'b11011;
    cyc(1);
    idle();
    lit("pre_reset", 5'b01000, 0, 1, 1);
    rst = 1'b1;
    bus.up = 1'b1;
    bus.open = 1'b1;
    bus.button_in = 5'b00000;
    cyc(1);
    rst = 1'b0;
    idle();
    lit("mid_reset", 5'b00001, 0, 0, 0);

    // Pseudo-random traffic, model-checked every cycle.
    for (int n = 0; n < 200; n++) begin
      bus.open = 1'($urandom_range(0, 3) == 0);
      bus.up = 1'($urandom_range(0, 1));
      bus.down = 1'($urandom_range(0, 1));
      if (bus.up && bus.down && (bus.i[N-1] || bus.i[0])) bus.down = 1'b0;
      bus.button_out = '1;
      bus.button_in = '1;
      if ($urandom_range(0, 3) == 0) bus.button_out[$urandom_range(0, N - 1)] = 1'b0;
      if ($urandom_range(0, 3) == 0) bus.button_in[$urandom_range(0, N - 1)] = 1'b0;
      cyc(1);
    end
    idle();
    cyc(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
